// File: rtl/ps2_pkg.sv
// ps2_pkg: frame FSM states and PS/2 byte constants shared by the keyboard encoder
package ps2_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_t;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_REL    = 8'hF0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  function automatic logic is_ignored(input logic [7:0] b);
    return b == PS2_BAT || b == PS2_ACK || b == PS2_ECHO || b == PS2_RESEND;
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronises the PS/2 lines, debounces the clock and strobes on its falling edge
module ps2_line_filter #(
  parameter int FILT = 4
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic strobe,
  output logic data_s
);
  localparam int CW = $clog2(FILT + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT - 1);
  logic [1:0] clk_q, data_q;
  logic fclk;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      clk_q  <= 2'b11;
      data_q <= 2'b11;
      fclk   <= 1'b1;
      cnt    <= '0;
    end else begin
      clk_q  <= {clk_q[0], ps2_clk};
      data_q <= {data_q[0], ps2_data};
      if (clk_q[1] == fclk) cnt <= '0;
      else if (cnt == LAST) begin
        fclk <= clk_q[1];
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  // strobe fires in the cycle the filtered clock is about to fall
  assign strobe = fclk && !clk_q[1] && cnt == LAST;
  assign data_s = data_q[1];
endmodule

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: receives PS/2 frames and assembles E0/F0 prefixes into the 11-bit ps2_key event word
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 24_000_000,
  parameter int TIMEOUT_US = 100,
  parameter int FILT       = 4
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);
  localparam int TC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TC + 1);
  localparam logic [TW-1:0] TO_TC = TW'(TC);
  ps2_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] sh, sh_n;
  logic par, par_n, ext, ext_n, rel, rel_n, err_n, timeout;
  logic [10:0] key_n;
  logic [TW-1:0] to_cnt, to_n;
  logic strobe, data_s;
  ps2_line_filter #(.FILT(FILT)) u_filt (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .strobe  (strobe),
    .data_s  (data_s)
  );
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      par       <= 1'b0;
      ext       <= 1'b0;
      rel       <= 1'b0;
      to_cnt    <= '0;
      ps2_key   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      sh        <= sh_n;
      par       <= par_n;
      ext       <= ext_n;
      rel       <= rel_n;
      to_cnt    <= to_n;
      ps2_key   <= key_n;
      frame_err <= err_n;
    end
  end
  // a strobe landing on the terminal count wins: the frame continues
  assign timeout = state != ST_IDLE && !strobe && to_cnt == TO_TC;
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    par_n     = par;
    ext_n     = ext;
    rel_n     = rel;
    key_n     = ps2_key;
    err_n     = 1'b0;
    to_n      = (state == ST_IDLE || strobe || timeout) ? '0 : to_cnt + 1'b1;
    if (timeout) begin
      state_n = ST_IDLE;
      err_n   = 1'b1;
      ext_n   = 1'b0;
      rel_n   = 1'b0;
    end else if (strobe) begin
      case (state)
        ST_IDLE: begin
          state_n   = data_s ? ST_IDLE : ST_DATA;
          bit_cnt_n = '0;
        end
        ST_DATA: begin
          sh_n      = {data_s, sh[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          state_n   = (bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          par_n   = data_s;
          state_n = ST_STOP;
        end
        default: begin
          state_n = ST_IDLE;
          if (!(^sh ^ par) || !data_s) begin
            err_n = 1'b1;
            ext_n = 1'b0;
            rel_n = 1'b0;
          end else if (sh == PS2_EXT) ext_n = 1'b1;
          else if (sh == PS2_REL) rel_n = 1'b1;
          else if (!is_ignored(sh)) begin
            key_n = {~ps2_key[10], ~rel, ext, sh};
            ext_n = 1'b0;
            rel_n = 1'b0;
          end
        end
      endcase
    end
  end
  assign busy = state != ST_IDLE;
endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed PS/2 frame vectors plus hand-written timeout and reset sequences
module tb_ps2_key_encoder;
  logic clk_sys = 1'b0, RESET = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic frame_err, busy;
  int n_vec = 0, n_bad = 0, n_err = 0, e0;
  localparam int HALF = 40;
  typedef struct {
    logic [7:0]  b;
    bit          bad;
    logic [10:0] key;
    int          err;
  } vec_t;
  vec_t vt[9];

  ps2_key_encoder #(.CLK_HZ(1_000_000), .TIMEOUT_US(100), .FILT(4)) dut (
    .clk_sys  (clk_sys),
    .RESET    (RESET),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #500 clk_sys = ~clk_sys;
  always @(posedge clk_sys) if (frame_err) n_err <= n_err + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      cyc(HALF / 2);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
      cyc(HALF / 2);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bad);
    logic p;
    p = ~(^b) ^ bad;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic apply(input int i);
    e0 = n_err;
    send_bits(frame(vt[i].b, vt[i].bad), 11);
    check($sformatf("key[%0d]", i), 32'(ps2_key), 32'(vt[i].key));
    check($sformatf("err[%0d]", i), n_err - e0, vt[i].err);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'hE0, 1'b0, 11'h61D, 0};
    vt[1] = '{8'h75, 1'b0, 11'h375, 0};
    vt[2] = '{8'hE0, 1'b0, 11'h375, 0};
    vt[3] = '{8'hF0, 1'b0, 11'h375, 0};
    vt[4] = '{8'h75, 1'b0, 11'h575, 0};
    vt[5] = '{8'h29, 1'b1, 11'h575, 1};
    vt[6] = '{8'h29, 1'b0, 11'h229, 0};
    vt[7] = '{8'h14, 1'b0, 11'h614, 0};
    vt[8] = '{8'hFA, 1'b0, 11'h614, 0};
    cyc(3);
    check("reset key", 32'(ps2_key), 0);
    check("reset busy", 32'(busy), 0);
    check("reset err", 32'(frame_err), 0);
    RESET = 1'b0;
    cyc(5);
    // make 0x1D with exact update timing around the stop strobe
    e0 = n_err;
    send_bits(frame(8'h1D, 1'b0), 10);
    check("busy in frame", 32'(busy), 1);
    ps2_data = 1'b1;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(3);
    check("key before stop strobe", 32'(ps2_key), 0);
    cyc(5);
    check("key after stop strobe", 32'(ps2_key), 32'h61D);
    check("busy after stop", 32'(busy), 0);
    cyc(HALF - 8);
    ps2_clk = 1'b1;
    cyc(HALF / 2);
    check("err 1D", n_err - e0, 0);
    for (int i = 0; i < 7; i++) apply(i);
    // clock stalls after start + 4 data bits
    e0 = n_err;
    send_bits(frame(8'h5A, 1'b0), 5);
    check("busy before timeout", 32'(busy), 1);
    cyc(150);
    check("busy after timeout", 32'(busy), 0);
    check("timeout err", n_err - e0, 1);
    check("key after timeout", 32'(ps2_key), 32'h229);
    for (int i = 7; i < 9; i++) apply(i);
    // reset in the middle of a frame
    e0 = n_err;
    send_bits(frame(8'h33, 1'b0), 5);
    check("busy before reset", 32'(busy), 1);
    RESET = 1'b1;
    cyc(1);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset key", 32'(ps2_key), 0);
    RESET = 1'b0;
    cyc(5);
    check("mid reset no err", n_err - e0, 0);
    send_bits(frame(8'h1D, 1'b0), 11);
    check("key after reset", 32'(ps2_key), 32'h61D);
    check("err after reset", n_err - e0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
